// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH x DATAWIDTH word memory with byte strobes.
// Inserts WAIT_CYCLES wait states per access; out-of-range addresses return PSLVERR.
module apb_slave_mem #(
   parameter int ADDWIDTH    = 8,
   parameter int DATAWIDTH   = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [ADDWIDTH-1:0]    PADDR,
   input  logic [DATAWIDTH-1:0]   PWDATA,
   input  logic [DATAWIDTH/8-1:0] PSTRB,
   output logic                   PREADY,
   output logic [DATAWIDTH-1:0]   PRDATA,
   output logic                   PSLVERR
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   localparam int         IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         NLANE    = DATAWIDTH / 8;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

   logic [0:0]           state;
   logic [3:0]           cnt;
   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [IDXW-1:0]      idx;
   logic                 addr_err;
   logic                 wr_en;

   assign idx      = PADDR[IDXW-1:0];
   assign addr_err = (64'(PADDR) >= 64'(DEPTH));

   // Address/control are taken live in the ready cycle; the requester holds them stable.
   assign PREADY  = (state == ACCESS) && PSEL && PENABLE && (cnt == WAIT_CNT);
   assign PSLVERR = PREADY && addr_err;
   assign wr_en   = PREADY && PWRITE && !addr_err;
   assign PRDATA  = (PREADY && !PWRITE && !addr_err) ? mem[idx] : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // PENABLE without a preceding setup phase is not a transfer.
               if (PSEL && !PENABLE) begin
                  state <= ACCESS;
                  cnt   <= '0;
               end
            end
            ACCESS: begin
               if (!PSEL || PREADY) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < NLANE; b++) begin
            if (PSTRB[b]) begin
               mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed scenarios for apb_slave_mem with a queue of expected completions and a word model.
module tb_apb_slave_mem;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int WAITS = 2;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          PSEL, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic          PREADY;
   logic [DW-1:0] PRDATA;
   logic          PSLVERR;

   apb_slave_mem #(.ADDWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   typedef struct {
      bit              wr;
      logic [AW-1:0]   a;
      logic [DW-1:0]   d;
      logic [DW/8-1:0] st;
      logic [DW-1:0]   rd;
      logic            err;
   } xf_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model [DEPTH];
   int            n_cmp = 0;
   int            n_bad = 0;

   logic [DW-1:0] obs_rdata;
   logic          obs_err;
   int            obs_waits;
   bit            obs_tmo;
   bit            obs_leak;

   // Setup phase, then access phase until PREADY (bounded); records what the bus showed.
   task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] st);
      bit done;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
      @(posedge PCLK); #1;
      PENABLE   = 1'b1;
      obs_waits = 0; obs_tmo = 0; obs_leak = 0; done = 0;
      while (!done) begin
         @(negedge PCLK);
         if (PREADY) begin
            done = 1;
         end else begin
            if (PRDATA !== '0 || PSLVERR !== 1'b0) obs_leak = 1;
            obs_waits++;
            if (obs_waits > 40) begin
               obs_tmo = 1;
               done    = 1;
            end else begin
               @(posedge PCLK); #1;
            end
         end
      end
      obs_rdata = PRDATA;
      obs_err   = PSLVERR;
      if (wr && int'(a) < DEPTH) begin
         for (int b = 0; b < DW/8; b++) begin
            if (st[b]) model[a][8*b +: 8] = wd[8*b +: 8];
         end
      end
   endtask

   task automatic bus_idle();
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0; PWDATA = '0; PADDR = '0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0;
      clear_model();
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      n_cmp++;
      if (PREADY !== 1'b0 || PRDATA !== '0 || PSLVERR !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: ready=%b rdata=%h err=%b, want 0/0/0", PREADY, PRDATA, PSLVERR);
      end
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      foreach (model[i]) begin
         if (i == 0 || i == 5 || i == DEPTH - 1) begin
            exp_t x;
            x.rdata = '0; x.err = 1'b0;
            exp_q.push_back(x);
            xfer(1'b0, AW'(i), '0, '0);
            x = exp_q.pop_front();
            n_cmp++;
            if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
               n_bad++;
               $display("FAIL reset_mem[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                        i, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
            end
         end
      end
      bus_idle();
   endtask

   task automatic test_write_read();
      xf_t t[2];
      exp_t x;
      t = '{'{1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0},
            '{1'b0, 8'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0}};
      foreach (t[i]) begin
         x.rdata = t[i].rd; x.err = t[i].err;
         exp_q.push_back(x);
         xfer(t[i].wr, t[i].a, t[i].d, t[i].st);
         x = exp_q.pop_front();
         n_cmp++;
         if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
            n_bad++;
            $display("FAIL write_read[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                     i, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
         end
         bus_idle();
      end
   endtask

   task automatic test_strobe();
      xf_t t[4];
      exp_t x;
      t = '{'{1'b1, 8'd5, 32'h11223344, 4'h5, 32'h0, 1'b0},
            '{1'b0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0},
            '{1'b1, 8'd5, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0},
            '{1'b0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0}};
      foreach (t[i]) begin
         x.rdata = t[i].rd; x.err = t[i].err;
         exp_q.push_back(x);
         xfer(t[i].wr, t[i].a, t[i].d, t[i].st);
         x = exp_q.pop_front();
         n_cmp++;
         if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
            n_bad++;
            $display("FAIL strobe[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                     i, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
         end
         bus_idle();
      end
   endtask

   task automatic test_error();
      xf_t t[3];
      exp_t x;
      t = '{'{1'b0, 8'd64,  32'h0, 4'h0, 32'h0, 1'b1},
            '{1'b1, 8'd64,  32'hCAFEF00D, 4'hF, 32'h0, 1'b1},
            '{1'b0, 8'd255, 32'h0, 4'h0, 32'h0, 1'b1}};
      foreach (t[i]) begin
         x.rdata = t[i].rd; x.err = t[i].err;
         exp_q.push_back(x);
         xfer(t[i].wr, t[i].a, t[i].d, t[i].st);
         x = exp_q.pop_front();
         n_cmp++;
         if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
            n_bad++;
            $display("FAIL error[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                     i, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
         end
         bus_idle();
      end
      // Whole-memory sweep: the rejected write must not have landed anywhere.
      for (int a = 0; a < DEPTH; a++) begin
         x.rdata = model[a]; x.err = 1'b0;
         exp_q.push_back(x);
         xfer(1'b0, AW'(a), '0, '0);
         x = exp_q.pop_front();
         n_cmp++;
         if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
            n_bad++;
            $display("FAIL sweep[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                     a, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
         end
      end
      bus_idle();
   endtask

   task automatic test_back_to_back();
      xf_t t[4];
      exp_t x;
      t = '{'{1'b1, 8'd10, 32'hA5A50F0F, 4'hF, 32'h0, 1'b0},
            '{1'b0, 8'd10, 32'h0, 4'h0, 32'hA5A50F0F, 1'b0},
            '{1'b1, 8'd63, 32'h12345678, 4'hF, 32'h0, 1'b0},
            '{1'b0, 8'd63, 32'h0, 4'h0, 32'h12345678, 1'b0}};
      foreach (t[i]) begin
         x.rdata = t[i].rd; x.err = t[i].err;
         exp_q.push_back(x);
         xfer(t[i].wr, t[i].a, t[i].d, t[i].st);
         x = exp_q.pop_front();
         n_cmp++;
         if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
            n_bad++;
            $display("FAIL b2b[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                     i, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
         end
      end
      bus_idle();
   endtask

   task automatic test_abort();
      bit   seen;
      exp_t x;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd20; PWDATA = 32'hBAD0BAD0; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      seen = PREADY;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (4) begin
         @(negedge PCLK);
         if (PREADY !== 1'b0 || PRDATA !== '0 || PSLVERR !== 1'b0) seen = 1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL abort_outputs: ready/rdata/err seen nonzero=%b, want 0", seen);
      end
      x.rdata = model[20]; x.err = 1'b0;
      exp_q.push_back(x);
      xfer(1'b0, 8'd20, '0, '0);
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
         n_bad++;
         $display("FAIL abort_next: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                  obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
      end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      bit   seen;
      exp_t x;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd21; PWDATA = 32'h5EED5EED; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      #1;
      seen = (PREADY !== 1'b0 || PRDATA !== '0 || PSLVERR !== 1'b0);
      clear_model();
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      // Requester still shows an access phase: without a fresh setup it must be ignored.
      repeat (4) begin
         @(negedge PCLK);
         if (PREADY !== 1'b0 || PRDATA !== '0 || PSLVERR !== 1'b0) seen = 1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL reset_mid_outputs: ready/rdata/err seen nonzero=%b, want 0", seen);
      end
      bus_idle();
      for (int k = 0; k < 2; k++) begin
         logic [AW-1:0] a;
         a = (k == 0) ? 8'd21 : 8'd5;
         x.rdata = model[a]; x.err = 1'b0;
         exp_q.push_back(x);
         xfer(1'b0, a, '0, '0);
         x = exp_q.pop_front();
         n_cmp++;
         if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
            n_bad++;
            $display("FAIL reset_mid_read[%0d]: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                     a, obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
         end
      end
      bus_idle();
   endtask

   task automatic test_no_setup();
      bit   seen;
      exp_t x;
      seen = 0;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'd7; PWDATA = 32'h77777777; PSTRB = 4'hF;
      repeat (6) begin
         @(negedge PCLK);
         if (PREADY !== 1'b0) seen = 1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL no_setup_ready: ready seen=%b, want 0", seen);
      end
      bus_idle();
      x.rdata = model[7]; x.err = 1'b0;
      exp_q.push_back(x);
      xfer(1'b0, 8'd7, '0, '0);
      x = exp_q.pop_front();
      n_cmp++;
      if (obs_tmo || obs_leak || obs_waits != WAITS || obs_rdata !== x.rdata || obs_err !== x.err) begin
         n_bad++;
         $display("FAIL no_setup_mem: rdata=%h err=%b waits=%0d leak=%b tmo=%b, want rdata=%h err=%b waits=%0d",
                  obs_rdata, obs_err, obs_waits, obs_leak, obs_tmo, x.rdata, x.err, WAITS);
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobe();
      test_error();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_no_setup();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
